// File: rtl/avalon_anemo_gen_pkg.sv
// Shared constants and types for the anemometer pulse generator.
package anemo_pkg;

    // Avalon bus geometry
    localparam int unsigned AVL_ADDR_W = 2;
    localparam int unsigned AVL_DATA_W = 32;

    // Register word addresses
    localparam logic [AVL_ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [AVL_ADDR_W-1:0] ADDR_PERIOD = 2'd1;
    localparam logic [AVL_ADDR_W-1:0] ADDR_HIGH   = 2'd2;
    localparam logic [AVL_ADDR_W-1:0] ADDR_COUNT  = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_BURST = 1;
    localparam int unsigned CTRL_START = 2;

    // Shortest period that still gives one high and one low cycle
    localparam int unsigned MIN_PERIOD = 2;

    typedef enum logic {
        IDLE,
        RUN
    } anemo_state_t;

endpackage

// File: rtl/avalon_anemo_gen_if.sv
// Avalon-MM slave bus bundle for the pulse generator register file.
interface avalon_anemo_gen_if;
    import anemo_pkg::*;

    logic                  chipselect;
    logic [AVL_ADDR_W-1:0] address;
    logic                  write_n;
    logic                  read_n;
    logic [AVL_DATA_W-1:0] writedata;
    logic [AVL_DATA_W-1:0] readdata;

    modport master (
        output chipselect, address, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, address, write_n, read_n, writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_anemo_gen_pulse_core.sv
// Phase counter, period/high shadows and burst counter of the pulse generator.
module anemo_pulse_core
    import anemo_pkg::*;
#(
    parameter int unsigned PERIOD_W = 32,
    parameter int unsigned BURST_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,      // one-cycle restart request
    input  logic                stop,       // one-cycle stop request
    input  logic                burst,      // burst mode select
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] high,
    input  logic [BURST_W-1:0]  count,
    output logic                anemo_out,
    output logic                busy,
    output logic [BURST_W-1:0]  remaining,
    output logic                burst_end   // last burst period ends this cycle
);

    anemo_state_t        state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] p_sh;
    logic [PERIOD_W-1:0] h_sh;

    logic [PERIOD_W-1:0] p_new;
    logic [PERIOD_W-1:0] h_new;
    logic [PERIOD_W-1:0] cnt_inc;
    logic                wrap;
    logic                last_pulse;

    // Clamped shadow candidates and wrap detection
    always_comb begin
        p_new      = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
        h_new      = (high > p_new - PERIOD_W'(1)) ? p_new - PERIOD_W'(1) : high;
        cnt_inc    = cnt + PERIOD_W'(1);
        wrap       = (cnt == p_sh - PERIOD_W'(1));
        last_pulse = burst && (remaining <= BURST_W'(1));
        burst_end  = (state == RUN) && wrap && last_pulse && !start && !stop;
    end

    // Pulse FSM: start beats stop beats the normal wrap/advance
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            p_sh      <= '0;
            h_sh      <= '0;
            remaining <= '0;
            anemo_out <= 1'b0;
            busy      <= 1'b0;
        end else if (start) begin
            state     <= RUN;
            cnt       <= '0;
            p_sh      <= p_new;
            h_sh      <= h_new;
            remaining <= count;
            anemo_out <= (h_new != '0);
            busy      <= 1'b1;
        end else if (stop) begin
            state     <= IDLE;
            cnt       <= '0;
            anemo_out <= 1'b0;
            busy      <= 1'b0;
        end else if (state == RUN) begin
            if (wrap) begin
                cnt <= '0;
                if (last_pulse) begin
                    state     <= IDLE;
                    remaining <= '0;
                    anemo_out <= 1'b0;
                    busy      <= 1'b0;
                end else begin
                    if (burst) begin
                        remaining <= remaining - BURST_W'(1);
                    end
                    p_sh      <= p_new;
                    h_sh      <= h_new;
                    anemo_out <= (h_new != '0);
                end
            end else begin
                cnt       <= cnt_inc;
                anemo_out <= (cnt_inc < h_sh);
            end
        end
    end

endmodule

// File: rtl/avalon_anemo_gen.sv
// Avalon-MM programmable anemometer pulse generator: register file + pulse core.
module avalon_anemo_gen
    import anemo_pkg::*;
#(
    parameter int unsigned PERIOD_W = 32,
    parameter int unsigned BURST_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    avalon_anemo_gen_if.slave  bus,
    output logic               anemo_out,
    output logic               busy
);

    logic                ctrl_en;
    logic                ctrl_burst;
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] high_reg;
    logic [BURST_W-1:0]  count_reg;
    logic                start_q;
    logic                stop_q;
    logic [BURST_W-1:0]  remaining;
    logic                burst_end;

    logic wr;
    logic rd;

    assign wr = bus.chipselect && !bus.write_n;
    assign rd = bus.chipselect && !bus.read_n;

    // Register writes; START/stop become one-cycle requests to the core
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en    <= 1'b0;
            ctrl_burst <= 1'b0;
            period_reg <= '0;
            high_reg   <= '0;
            count_reg  <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            if (burst_end) begin
                ctrl_en <= 1'b0;
            end
            if (wr) begin
                case (bus.address)
                    ADDR_CTRL: begin
                        ctrl_en    <= bus.writedata[CTRL_EN];
                        ctrl_burst <= bus.writedata[CTRL_BURST];
                        start_q    <= bus.writedata[CTRL_EN] && bus.writedata[CTRL_START];
                        stop_q     <= !bus.writedata[CTRL_EN];
                    end
                    ADDR_PERIOD: period_reg <= bus.writedata[PERIOD_W-1:0];
                    ADDR_HIGH:   high_reg   <= bus.writedata[PERIOD_W-1:0];
                    default:     count_reg  <= bus.writedata[BURST_W-1:0];
                endcase
            end
        end
    end

    // Registered read mux, one cycle of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (rd) begin
            case (bus.address)
                ADDR_CTRL: begin
                    bus.readdata             <= '0;
                    bus.readdata[CTRL_EN]    <= ctrl_en;
                    bus.readdata[CTRL_BURST] <= ctrl_burst;
                end
                ADDR_PERIOD: bus.readdata <= AVL_DATA_W'(period_reg);
                ADDR_HIGH:   bus.readdata <= AVL_DATA_W'(high_reg);
                default:     bus.readdata <= AVL_DATA_W'(remaining);
            endcase
        end
    end

    anemo_pulse_core #(
        .PERIOD_W (PERIOD_W),
        .BURST_W  (BURST_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (start_q),
        .stop      (stop_q),
        .burst     (ctrl_burst),
        .period    (period_reg),
        .high      (high_reg),
        .count     (count_reg),
        .anemo_out (anemo_out),
        .busy      (busy),
        .remaining (remaining),
        .burst_end (burst_end)
    );

endmodule

// File: tb/tb_avalon_anemo_gen.sv
// Directed self-checking bench for avalon_anemo_gen.
module tb_avalon_anemo_gen;

    logic clk;
    logic reset;
    logic anemo_out;
    logic busy;
    int   n_cmp;
    int   n_err;

    avalon_anemo_gen_if bus();

    avalon_anemo_gen #(
        .PERIOD_W (32),
        .BURST_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .anemo_out (anemo_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called 1ns after an edge; the write is sampled at the next edge
    task automatic avl_write(input logic [1:0] addr, input logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic avl_read(input logic [1:0] addr, output logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.address    = addr;
        bus.read_n     = 1'b0;
        @(posedge clk); #1;
        data           = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Sample n cycles starting at the edge where the core starts (cnt=0)
    task automatic sample_train(input int n, input int period, input int high,
                                output int err, output int highs);
        err   = 0;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (anemo_out) highs++;
            if (anemo_out !== ((i % period) < high)) err++;
        end
    endtask

    logic [31:0] rdata;
    int          err;
    int          highs;
    logic        trace_ok;

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.address    = '0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.writedata  = '0;
        step(3);
        check_val("rst_anemo", 32'(anemo_out), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_readdata", bus.readdata, 0);
        reset = 1'b0;
        step(1);

        // Continuous: 3 high / 7 low
        avl_write(2'd1, 32'd10);
        avl_write(2'd2, 32'd3);
        avl_write(2'd0, 32'h5);
        check_val("cont_busy_before", 32'(busy), 0);
        sample_train(30, 10, 3, err, highs);
        check_val("cont_pattern_err", err, 0);
        check_val("cont_highs", highs, 9);
        check_val("cont_busy", 32'(busy), 1);
        avl_write(2'd0, 32'h0);
        step(1);
        check_val("cont_stop_busy", 32'(busy), 0);

        // Burst of 4 pulses
        avl_write(2'd3, 32'd4);
        avl_write(2'd1, 32'd8);
        avl_write(2'd2, 32'd4);
        avl_write(2'd0, 32'h7);
        sample_train(32, 8, 4, err, highs);
        check_val("burst_pattern_err", err, 0);
        check_val("burst_highs", highs, 16);
        check_val("burst_busy_last", 32'(busy), 1);
        step(1);
        check_val("burst_busy_end", 32'(busy), 0);
        sample_train(10, 10, 0, err, highs);
        check_val("burst_no_extra", highs, 0);
        avl_read(2'd0, rdata);
        check_val("burst_ctrl_rd", rdata, 32'h2);
        avl_read(2'd3, rdata);
        check_val("burst_count_rd", rdata, 0);

        // Clamp: PERIOD=1, HIGH=5 -> period 2, high 1
        avl_write(2'd1, 32'd1);
        avl_write(2'd2, 32'd5);
        avl_write(2'd0, 32'h5);
        sample_train(10, 2, 1, err, highs);
        check_val("clamp_p1_err", err, 0);
        avl_write(2'd0, 32'h0);

        // Clamp: HIGH=0 -> low while busy
        avl_write(2'd1, 32'd4);
        avl_write(2'd2, 32'd0);
        avl_write(2'd0, 32'h5);
        sample_train(12, 4, 0, err, highs);
        check_val("clamp_h0_highs", highs, 0);
        check_val("clamp_h0_busy", 32'(busy), 1);
        avl_write(2'd0, 32'h0);

        // Mid-period PERIOD update: 10-cycle period completes, then 6
        avl_write(2'd1, 32'd10);
        avl_write(2'd2, 32'd3);
        avl_write(2'd0, 32'h5);
        err = 0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            trace_ok = (i < 10) ? (anemo_out === (i < 3)) : (anemo_out === (((i - 10) % 6) < 3));
            if (!trace_ok) err++;
            if (i == 2) begin
                bus.chipselect = 1'b1;
                bus.address    = 2'd1;
                bus.writedata  = 32'd6;
                bus.write_n    = 1'b0;
            end
            if (i == 3) begin
                bus.chipselect = 1'b0;
                bus.write_n    = 1'b1;
            end
        end
        check_val("midupd_err", err, 0);
        avl_write(2'd0, 32'h0);

        // Stop mid-burst
        avl_write(2'd3, 32'd5);
        avl_write(2'd1, 32'd6);
        avl_write(2'd2, 32'd3);
        avl_write(2'd0, 32'h7);
        step(2);
        check_val("stop_pre_high", 32'(anemo_out), 1);
        avl_write(2'd0, 32'h2);
        step(1);
        check_val("stop_anemo", 32'(anemo_out), 0);
        check_val("stop_busy", 32'(busy), 0);
        sample_train(8, 8, 0, err, highs);
        check_val("stop_stays_low", highs, 0);

        // Restart during RUN reloads count and cnt
        avl_write(2'd3, 32'd3);
        avl_write(2'd1, 32'd5);
        avl_write(2'd2, 32'd2);
        avl_write(2'd0, 32'h7);
        step(7);
        avl_write(2'd0, 32'h7);
        sample_train(15, 5, 2, err, highs);
        check_val("restart_pattern_err", err, 0);
        check_val("restart_busy_last", 32'(busy), 1);
        step(1);
        check_val("restart_busy_end", 32'(busy), 0);

        // Unused CTRL bits read as 0
        avl_write(2'd0, 32'hFFFF_FFFA);
        avl_read(2'd0, rdata);
        check_val("ctrl_unused_rd", rdata, 32'h2);

        // Reset mid-high-phase
        avl_write(2'd1, 32'h1234);
        avl_read(2'd1, rdata);
        check_val("period_rd", rdata, 32'h1234);
        avl_write(2'd2, 32'd100);
        avl_write(2'd0, 32'h5);
        step(3);
        check_val("rst_pre_high", 32'(anemo_out), 1);
        reset = 1'b1;
        step(1);
        check_val("midrst_anemo", 32'(anemo_out), 0);
        check_val("midrst_busy", 32'(busy), 0);
        check_val("midrst_readdata", bus.readdata, 0);
        reset = 1'b0;
        avl_read(2'd0, rdata);
        check_val("midrst_ctrl_rd", rdata, 0);
        avl_read(2'd1, rdata);
        check_val("midrst_period_rd", rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
